// File: rtl/result_collector.sv
// result_collector: gathers DIM consecutive dot-product sums from the adder
// into one result row and hands rows downstream over valid/ready.
// One fill register plus one output register, so the adder can keep
// producing while a completed row waits for the consumer.
//
// state | meaning
// IDLE  | no partial row in the fill register
// FILL  | partial row being collected
// STALL | fill register holds a complete row, output register still occupied
module result_collector #(
    parameter int DIM   = 2,
    parameter int WIDTH = 17
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [WIDTH-1:0]     sum_i,
    input  logic                 finished_i,
    output logic [DIM*WIDTH-1:0] row_out_o,
    output logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] row_index_o,
    output logic                 row_valid_o,
    input  logic                 row_ready_i,
    output logic                 matrix_done_o,
    output logic                 overflow_o,
    output logic                 busy_o
);

    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          col_q;
    logic [IW-1:0]          row_cnt_q;
    logic [DIM*WIDTH-1:0]   fill_q;
    logic [DIM*WIDTH-1:0]   fill_d;
    logic [DIM*WIDTH-1:0]   row_out_q;
    logic [IW-1:0]          row_index_q;
    logic                   row_valid_q;
    logic                   done_q;
    logic                   overflow_q;

    logic                   take_sum;
    logic                   last_sum;
    logic                   can_xfer;
    logic                   accept;
    logic                   xfer;

    // Sums are only taken outside STALL; the final sum of a row may go straight
    // to the output register on the same edge it arrives.
    assign take_sum = finished_i && (state_q != STALL);
    assign last_sum = take_sum && (col_q == LAST);
    assign can_xfer = !row_valid_q || row_ready_i;
    assign accept   = row_valid_q && row_ready_i;
    assign xfer     = can_xfer && (last_sum || (state_q == STALL));

    // Fill contents including this cycle's sum, so a completing row transfers without a bubble.
    always_comb begin
        fill_d = fill_q;
        if (take_sum) begin
            fill_d[col_q*WIDTH +: WIDTH] = sum_i;
        end
    end

    // Single registered FSM with its datapath and outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_cnt_q   <= '0;
            fill_q      <= '0;
            row_out_q   <= '0;
            row_index_q <= '0;
            row_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_cnt_q   <= '0;
            fill_q      <= '0;
            row_out_q   <= '0;
            row_index_q <= '0;
            row_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= accept && (row_index_q == LAST);

            if (take_sum) begin
                fill_q <= fill_d;
                col_q  <= (col_q == LAST) ? '0 : col_q + 1'b1;
            end else if (finished_i) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (finished_i) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (last_sum) begin
                        state_q <= can_xfer ? IDLE : STALL;
                    end
                end
                STALL: begin
                    if (can_xfer) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (xfer) begin
                row_out_q   <= fill_d;
                row_index_q <= row_cnt_q;
                row_valid_q <= 1'b1;
                row_cnt_q   <= (row_cnt_q == LAST) ? '0 : row_cnt_q + 1'b1;
            end else if (accept) begin
                row_valid_q <= 1'b0;
            end
        end
    end

    assign row_out_o     = row_out_q;
    assign row_index_o   = row_index_q;
    assign row_valid_o   = row_valid_q;
    assign matrix_done_o = done_q;
    assign overflow_o    = overflow_q;
    assign busy_o        = (state_q != IDLE) || row_valid_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector at DIM=2, WIDTH=17.
module tb_result_collector;

    localparam int DIM   = 2;
    localparam int WIDTH = 17;

    logic                 clk;
    logic                 rst_n;
    logic                 clear;
    logic [WIDTH-1:0]     sum;
    logic                 finished;
    logic [DIM*WIDTH-1:0] row_out;
    logic [0:0]           row_index;
    logic                 row_valid;
    logic                 row_ready;
    logic                 matrix_done;
    logic                 overflow;
    logic                 busy;

    int checks   = 0;
    int failures = 0;

    result_collector #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .sum_i         (sum),
        .finished_i    (finished),
        .row_out_o     (row_out),
        .row_index_o   (row_index),
        .row_valid_o   (row_valid),
        .row_ready_i   (row_ready),
        .matrix_done_o (matrix_done),
        .overflow_o    (overflow),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] pk(input logic [16:0] c1, input logic [16:0] c0);
        return {c1, c0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".row_out"}, 64'(row_out), 64'd0);
        chk({tag, ".row_index"}, 64'(row_index), 64'd0);
        chk({tag, ".row_valid"}, 64'(row_valid), 64'd0);
        chk({tag, ".done"}, 64'(matrix_done), 64'd0);
        chk({tag, ".overflow"}, 64'(overflow), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_row(input string tag, input logic v, input logic [33:0] r, input logic idx);
        chk({tag, ".valid"}, 64'(row_valid), 64'(v));
        chk({tag, ".row"}, 64'(row_out), 64'(r));
        chk({tag, ".idx"}, 64'(row_index), 64'(idx));
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; sum = '0; finished = 1'b0; row_ready = 1'b0;

        // 1: reset held with finished toggling
        for (int i = 0; i < 4; i++) begin
            finished = ~finished;
            sum = 17'(i + 3);
            step();
            chk_zero("rst_hold");
        end
        finished = 1'b0;
        rst_n = 1'b1;
        step();
        chk_zero("rst_release");

        // 2: two sums of 8
        row_ready = 1'b1;
        finished = 1'b1; sum = 17'd8;
        step();
        chk("t2.valid_mid", 64'(row_valid), 64'd0);
        chk("t2.busy_mid", 64'(busy), 64'd1);
        step();
        finished = 1'b0;
        chk_row("t2", 1'b1, pk(17'd8, 17'd8), 1'b0);
        chk("t2.overflow", 64'(overflow), 64'd0);
        step();
        chk("t2.valid_after", 64'(row_valid), 64'd0);
        chk("t2.done", 64'(matrix_done), 64'd0);

        // clear overrides a concurrent finished
        clear = 1'b1; finished = 1'b1; sum = 17'd99;
        step();
        clear = 1'b0; finished = 1'b0;
        chk_zero("clear1");

        // 3: sums 1..4 back to back, consumer always ready
        row_ready = 1'b1;
        finished = 1'b1;
        sum = 17'd1; step();
        sum = 17'd2; step();
        chk_row("t3.r0", 1'b1, pk(17'd2, 17'd1), 1'b0);
        sum = 17'd3; step();
        chk("t3.r0_taken", 64'(row_valid), 64'd0);
        chk("t3.done0", 64'(matrix_done), 64'd0);
        sum = 17'd4; step();
        finished = 1'b0;
        chk_row("t3.r1", 1'b1, pk(17'd4, 17'd3), 1'b1);
        step();
        chk("t3.done1", 64'(matrix_done), 64'd1);
        chk("t3.valid_end", 64'(row_valid), 64'd0);
        step();
        chk("t3.done_pulse", 64'(matrix_done), 64'd0);
        chk("t3.busy_end", 64'(busy), 64'd0);

        // 4: consumer stalled, sums 1..6
        row_ready = 1'b0;
        finished = 1'b1;
        sum = 17'd1; step();
        sum = 17'd2; step();
        chk_row("t4.r0", 1'b1, pk(17'd2, 17'd1), 1'b0);
        sum = 17'd3; step();
        sum = 17'd4; step();
        chk_row("t4.hold", 1'b1, pk(17'd2, 17'd1), 1'b0);
        chk("t4.ovf_before", 64'(overflow), 64'd0);
        sum = 17'd5; step();
        chk("t4.ovf", 64'(overflow), 64'd1);
        sum = 17'd6; step();
        finished = 1'b0;
        chk_row("t4.hold2", 1'b1, pk(17'd2, 17'd1), 1'b0);
        chk("t4.busy", 64'(busy), 64'd1);
        row_ready = 1'b1;
        step();
        chk_row("t4.r1", 1'b1, pk(17'd4, 17'd3), 1'b1);
        chk("t4.done0", 64'(matrix_done), 64'd0);
        step();
        chk("t4.valid_end", 64'(row_valid), 64'd0);
        chk("t4.done1", 64'(matrix_done), 64'd1);
        chk("t4.ovf_sticky", 64'(overflow), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_zero("clear2");

        // 5: row completes on the edge the held row is accepted
        row_ready = 1'b0;
        finished = 1'b1;
        sum = 17'd1; step();
        sum = 17'd2; step();
        sum = 17'd3; step();
        chk_row("t5.held", 1'b1, pk(17'd2, 17'd1), 1'b0);
        row_ready = 1'b1;
        sum = 17'd4; step();
        finished = 1'b0;
        chk_row("t5.swap", 1'b1, pk(17'd4, 17'd3), 1'b1);
        chk("t5.done0", 64'(matrix_done), 64'd0);
        step();
        chk("t5.valid_end", 64'(row_valid), 64'd0);
        chk("t5.done1", 64'(matrix_done), 64'd1);
        chk("t5.ovf", 64'(overflow), 64'd0);

        // 6a: async reset pulse discards a partial row
        finished = 1'b1; sum = 17'd7; step();
        finished = 1'b0;
        chk("t6a.busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("t6a.async");
        #1;
        rst_n = 1'b1;
        finished = 1'b1;
        sum = 17'd9; step();
        sum = 17'd5; step();
        finished = 1'b0;
        chk_row("t6a.row", 1'b1, pk(17'd5, 17'd9), 1'b0);
        step();
        chk("t6a.valid_end", 64'(row_valid), 64'd0);

        // 6b: same with clear
        finished = 1'b1; sum = 17'd7; step();
        clear = 1'b1; sum = 17'd11; step();
        clear = 1'b0;
        chk_zero("t6b.clear");
        sum = 17'd9; step();
        sum = 17'd5; step();
        finished = 1'b0;
        chk_row("t6b.row", 1'b1, pk(17'd5, 17'd9), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
